// File: rtl/uart_pkg.sv
// Shared definitions for the UART parity generator: mode encodings,
// FSM states and the parity helper functions.
package uart_pkg;

    // Widest frame the helpers are sized for
    localparam int MAX_DATA_WIDTH = 16;
    localparam int LEN_EXT_W      = 5;

    typedef logic [LEN_EXT_W-1:0] len_t;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } par_state_e;

    // Turn the raw XOR of the active data bits into the line parity bit
    function automatic logic apply_par_mode(input par_mode_e mode, input logic raw_xor);
        logic result;
        case (mode)
            PAR_EVEN:  result = raw_xor;
            PAR_ODD:   result = ~raw_xor;
            PAR_MARK:  result = 1'b1;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

    // XOR of data bits [len-1:0]; bits at or above len do not contribute
    function automatic logic masked_xor(input logic [MAX_DATA_WIDTH-1:0] data, input len_t len);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (len_t'(i) < len) begin
                acc = acc ^ data[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parametrised UART parity generator. SERIAL=0 computes the parity in one
// edge; SERIAL=1 walks the data one bit per edge and reports busy meanwhile.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SERIAL     = 0,
    parameter int LEN_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic [LEN_W-1:0]      DATA_LEN,
    output logic                  par_bit,
    output logic                  par_valid,
    output logic                  busy
);

    len_t eff_len;
    logic accept;

    // Effective length: zero or oversize requests fall back to the full width
    always_comb begin
        eff_len = len_t'(DATA_WIDTH);
        if (DATA_LEN != '0 && 32'(DATA_LEN) <= 32'(DATA_WIDTH)) begin
            eff_len = len_t'(DATA_LEN);
        end
    end

    assign accept = Data_Valid & PAR_EN & ~busy;

    generate
        if (SERIAL == 0) begin : g_parallel

            logic [MAX_DATA_WIDTH-1:0] data_ext;
            logic                      par_bit_reg;
            logic                      par_bit_next;
            logic                      par_valid_reg;
            logic                      par_valid_next;

            // Zero-pad the frame to the helper width
            for (genvar gi = 0; gi < MAX_DATA_WIDTH; gi++) begin : g_ext
                if (gi < DATA_WIDTH) begin : g_bit
                    assign data_ext[gi] = P_DATA[gi];
                end else begin : g_pad
                    assign data_ext[gi] = 1'b0;
                end
            end

            // One-edge parity from the live inputs on every accepted request
            always_comb begin
                par_bit_next   = par_bit_reg;
                par_valid_next = 1'b0;
                if (accept) begin
                    par_bit_next   = apply_par_mode(par_mode_e'(PAR_MODE),
                                                    masked_xor(data_ext, eff_len));
                    par_valid_next = 1'b1;
                end
            end

            // Result registers
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    par_bit_reg   <= 1'b0;
                    par_valid_reg <= 1'b0;
                end else begin
                    par_bit_reg   <= par_bit_next;
                    par_valid_reg <= par_valid_next;
                end
            end

            assign par_bit   = par_bit_reg;
            assign par_valid = par_valid_reg;
            assign busy      = 1'b0;

        end else begin : g_serial

            par_state_e            state_reg;
            par_state_e            state_next;
            logic [DATA_WIDTH-1:0] shift_reg;
            logic [DATA_WIDTH-1:0] shift_next;
            len_t                  cnt_reg;
            len_t                  cnt_next;
            len_t                  len_reg;
            len_t                  len_next;
            par_mode_e             mode_reg;
            par_mode_e             mode_next;
            logic                  acc_reg;
            logic                  acc_next;
            logic                  par_bit_reg;
            logic                  par_bit_next;
            logic                  par_valid_reg;
            logic                  par_valid_next;

            // Capture in IDLE, then fold one bit per edge; the last bit is
            // folded straight into the result so latency equals the length
            always_comb begin
                state_next     = state_reg;
                shift_next     = shift_reg;
                cnt_next       = cnt_reg;
                len_next       = len_reg;
                mode_next      = mode_reg;
                acc_next       = acc_reg;
                par_bit_next   = par_bit_reg;
                par_valid_next = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            state_next = CALC;
                            shift_next = P_DATA;
                            cnt_next   = '0;
                            len_next   = eff_len;
                            mode_next  = par_mode_e'(PAR_MODE);
                            acc_next   = 1'b0;
                        end
                    end
                    CALC: begin
                        if (cnt_reg == len_reg - len_t'(1)) begin
                            par_bit_next   = apply_par_mode(mode_reg, acc_reg ^ shift_reg[0]);
                            par_valid_next = 1'b1;
                            state_next     = IDLE;
                            cnt_next       = '0;
                            acc_next       = 1'b0;
                        end else begin
                            acc_next   = acc_reg ^ shift_reg[0];
                            shift_next = shift_reg >> 1;
                            cnt_next   = cnt_reg + len_t'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            // State and datapath registers; reset aborts any calculation
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    state_reg     <= IDLE;
                    shift_reg     <= '0;
                    cnt_reg       <= '0;
                    len_reg       <= '0;
                    mode_reg      <= PAR_EVEN;
                    acc_reg       <= 1'b0;
                    par_bit_reg   <= 1'b0;
                    par_valid_reg <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    shift_reg     <= shift_next;
                    cnt_reg       <= cnt_next;
                    len_reg       <= len_next;
                    mode_reg      <= mode_next;
                    acc_reg       <= acc_next;
                    par_bit_reg   <= par_bit_next;
                    par_valid_reg <= par_valid_next;
                end
            end

            assign par_bit   = par_bit_reg;
            assign par_valid = par_valid_reg;
            assign busy      = (state_reg == CALC);

        end
    endgenerate

endmodule

// File: tb/tb_uart_parity_gen.sv
// Bench for uart_parity_gen: drives a parallel and a serial instance with the
// same stimulus and checks both against a timeline reference model.
module tb_uart_parity_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] p_data = '0;
    logic       dv = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = '0;
    logic [3:0] dlen = '0;

    logic par_bit_p, par_valid_p, busy_p;
    logic par_bit_s, par_valid_s, busy_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state
    logic m_p_bit, m_p_valid;
    logic m_s_bit, m_s_valid, m_s_pending, m_s_val;
    int   m_s_left;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [1:0] mode;
        logic       exp;
    } vec_t;

    vec_t tbl [10];

    always #5 CLK = ~CLK;

    uart_parity_gen #(.DATA_WIDTH(8), .SERIAL(0), .LEN_W(4)) u_par (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data),
        .Data_Valid (dv),
        .PAR_EN     (en),
        .PAR_MODE   (mode),
        .DATA_LEN   (dlen),
        .par_bit    (par_bit_p),
        .par_valid  (par_valid_p),
        .busy       (busy_p)
    );

    uart_parity_gen #(.DATA_WIDTH(8), .SERIAL(1), .LEN_W(4)) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data),
        .Data_Valid (dv),
        .PAR_EN     (en),
        .PAR_MODE   (mode),
        .DATA_LEN   (dlen),
        .par_bit    (par_bit_s),
        .par_valid  (par_valid_s),
        .busy       (busy_s)
    );

    function automatic int ref_len(input int len);
        return (len >= 1 && len <= 8) ? len : 8;
    endfunction

    // Parity by counting ones over the active bits
    function automatic logic ref_parity(input logic [7:0] d, input int len, input logic [1:0] m);
        int l;
        int ones;
        l = ref_len(len);
        ones = 0;
        for (int i = 0; i < l; i++) ones += int'(d[i]);
        case (m)
            2'd0:    return (ones % 2) == 1;
            2'd1:    return (ones % 2) == 0;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_p_bit     = 1'b0;
        m_p_valid   = 1'b0;
        m_s_bit     = 1'b0;
        m_s_valid   = 1'b0;
        m_s_pending = 1'b0;
        m_s_val     = 1'b0;
        m_s_left    = 0;
    endtask

    task automatic compare_all();
        chk("par_bit_p",   par_bit_p,   m_p_bit);
        chk("par_valid_p", par_valid_p, m_p_valid);
        chk("busy_p",      busy_p,      1'b0);
        chk("par_bit_s",   par_bit_s,   m_s_bit);
        chk("par_valid_s", par_valid_s, m_s_valid);
        chk("busy_s",      busy_s,      m_s_pending);
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare
    task automatic step();
        logic req;
        @(posedge CLK);
        cyc++;
        req = dv && en;
        if (!RST) begin
            model_reset();
        end else begin
            m_p_valid = 1'b0;
            if (req) begin
                m_p_bit   = ref_parity(p_data, int'(dlen), mode);
                m_p_valid = 1'b1;
                $display("cycle %0d parallel data=%h len=%0d mode=%0d par_bit=%b",
                         cyc, p_data, dlen, mode, m_p_bit);
            end
            m_s_valid = 1'b0;
            if (m_s_pending) begin
                m_s_left--;
                if (m_s_left == 0) begin
                    m_s_bit     = m_s_val;
                    m_s_valid   = 1'b1;
                    m_s_pending = 1'b0;
                    $display("cycle %0d serial result par_bit=%b", cyc, m_s_bit);
                end
            end else if (req) begin
                m_s_pending = 1'b1;
                m_s_left    = ref_len(int'(dlen));
                m_s_val     = ref_parity(p_data, int'(dlen), mode);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic wait_ser_idle();
        int n;
        n  = 0;
        dv = 1'b0;
        while (busy_s && n < 40) begin
            step();
            n++;
        end
        chk("ser_idle_timeout", busy_s, 1'b0);
    endtask

    task automatic request(input logic [7:0] d, input logic [3:0] l, input logic [1:0] m);
        dv     = 1'b1;
        en     = 1'b1;
        p_data = d;
        dlen   = l;
        mode   = m;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 4'd8,  2'd0, 1'b0};
        tbl[1] = '{8'hA5, 4'd8,  2'd1, 1'b1};
        tbl[2] = '{8'hFF, 4'd7,  2'd0, 1'b1};
        tbl[3] = '{8'hFF, 4'd0,  2'd0, 1'b0};
        tbl[4] = '{8'hFF, 4'd12, 2'd0, 1'b0};
        tbl[5] = '{8'h01, 4'd1,  2'd1, 1'b0};
        tbl[6] = '{8'h80, 4'd7,  2'd0, 1'b0};
        tbl[7] = '{8'h80, 4'd8,  2'd0, 1'b1};
        tbl[8] = '{8'h3C, 4'd3,  2'd2, 1'b1};
        tbl[9] = '{8'h3C, 4'd3,  2'd3, 1'b0};

        model_reset();

        // Reset state
        #1 RST = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();

        // Table vectors, back-to-back on the parallel instance
        for (int i = 0; i < 10; i++) begin
            request(tbl[i].data, tbl[i].len, tbl[i].mode);
            step();
            chk("tbl_par_bit", par_bit_p, tbl[i].exp);
            chk("tbl_par_valid", par_valid_p, 1'b1);
        end
        dv = 1'b0;
        step();
        chk("par_valid_drop", par_valid_p, 1'b0);
        wait_ser_idle();

        // Serial 0x01, L=8, odd, with an ignored request at k+3
        request(8'h01, 4'd8, 2'd1);
        step();
        chk("ser_busy_start", busy_s, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            dv     = (j == 3);
            p_data = 8'h03;
            step();
            chk("ser_busy_window", busy_s, (j < 8));
            chk("ser_valid_time", par_valid_s, (j == 8));
            if (j == 8) chk("ser_odd_bit", par_bit_s, 1'b0);
        end

        // Serial mark then space, L=5, second accept at k+L+1
        request(8'($urandom), 4'd5, 2'd2);
        step();
        dv = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("ser_mark_valid", par_valid_s, (j == 5));
        end
        chk("ser_mark_bit", par_bit_s, 1'b1);
        request(8'($urandom), 4'd5, 2'd3);
        step();
        chk("ser_b2b_accept", busy_s, 1'b1);
        dv = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("ser_space_valid", par_valid_s, (j == 5));
        end
        chk("ser_space_bit", par_bit_s, 1'b0);

        // Reset in the middle of a serial calculation
        request(8'hA5, 4'd8, 2'd1);
        step();
        dv = 1'b0;
        for (int j = 1; j <= 4; j++) step();
        chk("pre_reset_par_bit", par_bit_p, 1'b1);
        RST = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        step();
        RST = 1'b1;
        for (int j = 0; j < 12; j++) step();
        request(8'h07, 4'd3, 2'd0);
        step();
        dv = 1'b0;
        wait_ser_idle();
        chk("ser_post_reset_bit", par_bit_s, 1'b1);

        // PAR_EN low: requests ignored, previous odd result held
        request(8'h00, 4'd8, 2'd1);
        step();
        wait_ser_idle();
        for (int j = 0; j < 5; j++) begin
            dv     = 1'b1;
            en     = 1'b0;
            p_data = 8'($urandom);
            mode   = 2'($urandom_range(0, 3));
            step();
            chk("en_low_valid_p", par_valid_p, 1'b0);
            chk("en_low_valid_s", par_valid_s, 1'b0);
            chk("en_low_hold_p", par_bit_p, 1'b1);
            chk("en_low_hold_s", par_bit_s, 1'b1);
        end

        // Randomized traffic against the model
        for (int j = 0; j < 400; j++) begin
            dv     = ($urandom_range(0, 3) != 0);
            en     = ($urandom_range(0, 7) != 0);
            p_data = 8'($urandom);
            dlen   = 4'($urandom_range(0, 15));
            mode   = 2'($urandom_range(0, 3));
            step();
        end
        wait_ser_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_parity_gen.md
Name: uart_parity_gen

Overview:
Parametrised parity generator for the UART transmitter, replacing the fixed 8-bit even/odd parity calculator. It supports configurable data width, a run-time frame length, and four parity modes (even, odd, mark, space). Each word is captured on Data_Valid. The parity bit is produced either in one cycle (parallel) or by a bit-serial accumulator with a busy/valid handshake toward the Tx FSM.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal 1..16)
SERIAL, 0, 0 = parallel one-cycle calculation; 1 = bit-serial accumulation, one bit per cycle
LEN_W, 4, width of DATA_LEN; must hold the value DATA_WIDTH

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-low
P_DATA  in  DATA_WIDTH  frame data, LSB = first bit on the line
Data_Valid  in  1  capture request, sampled on a CLK edge
PAR_EN  in  1  parity enable; 0 = request ignored
PAR_MODE  in  2  00 even, 01 odd, 10 mark, 11 space
DATA_LEN  in  LEN_W  active data bits, LSBs of P_DATA
par_bit  out  1  computed parity bit, held until the next result
par_valid  out  1  one-cycle pulse when par_bit updates
busy  out  1  serial calculation in progress

Behaviour:
- Reset (RST low, asynchronous): par_bit=0, par_valid=0, busy=0, FSM=IDLE, accumulator=0, bit counter=0.
- Accept condition: Data_Valid & PAR_EN & !busy at a CLK edge. P_DATA, PAR_MODE and the effective length L are captured on that edge.
- Effective length L: DATA_LEN if 1 <= DATA_LEN <= DATA_WIDTH. Otherwise L = DATA_WIDTH (both 0 and oversize values clamp to DATA_WIDTH).
- Bits at index >= L are excluded from the parity.
- Parity rule, with X = XOR of bits [L-1:0]:
  - even: par_bit = X (total ones including par_bit is even)
  - odd: par_bit = ~X
  - mark: par_bit = 1
  - space: par_bit = 0
- SERIAL=0:
  - On an accept edge, par_bit is computed from the live inputs and par_valid=1 on that same edge.
  - Latency is 1 edge. busy stays 0 at all times.
  - Back-to-back Data_Valid produces back-to-back results; par_valid stays high while requests are accepted every cycle.
- SERIAL=1, FSM IDLE -> CALC -> IDLE:
  - IDLE: on an accept at edge k, capture the shift register, mode and L; clear the accumulator; counter = 0; busy=1; go to CALC.
  - CALC: each edge XORs shift[0] into the accumulator, shifts right and increments the counter.
  - On the edge where the counter reaches L-1 (edge k+L), par_bit is written from the final XOR and mode, par_valid=1, busy=0, and the FSM returns to IDLE.
  - Total latency is L edges after capture. Mark and space modes use the same latency for timing consistency.
  - The earliest next accept is edge k+L+1.
- par_valid is 0 on every edge that does not produce a result.
- Data_Valid while busy=1 is ignored: no capture, no error, and the in-flight result is unaffected.
- Changes to PAR_MODE, DATA_LEN or P_DATA while busy=1 do not affect the in-flight result.
- PAR_EN=0 at the request edge: no capture, par_valid stays 0, par_bit holds its value.
- Reset asserted mid-CALC aborts immediately to the reset values. No result is produced after reset releases.

Decomposition:
- Shared package uart_pkg holds:
  - PAR_MODE encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE)
  - the FSM state typedef (IDLE, CALC)
  - a function that applies the mode to the raw XOR
- Parallel mode needs a masked XOR-reduction function, also in the package.
- No sub-module. The serial datapath (shift register, counter, accumulator) is small enough to stay inline, selected by a generate on SERIAL.

Test Plan:
- SERIAL=0, P_DATA=0xA5, L=8, even -> par_bit=0 and par_valid=1 for exactly 1 cycle after the accept edge. Same input in odd mode -> par_bit=1.
- SERIAL=0, P_DATA=0xFF, DATA_LEN=7, even -> par_bit=1 (bit 7 masked). DATA_LEN=0 -> treated as 8 -> par_bit=0.
- SERIAL=1, P_DATA=0x01, L=8, odd:
  - busy high for 8 edges
  - par_valid pulses at edge k+8 with par_bit=0
  - a Data_Valid with 0x03 at edge k+3 is ignored
- SERIAL=1, mark mode and then space mode, any data, L=5 -> par_bit=1 then 0, each with latency 5 edges. Accepting back-to-back at edge k+L+1 works.
- RST pulsed low at edge k+4 of a serial calculation -> busy, par_bit and par_valid go to 0 immediately, with no par_valid pulse afterwards. A new request after release completes normally.
- PAR_EN=0 with Data_Valid=1 -> par_valid never asserts and par_bit holds its previous value (1 from the prior odd-mode test).
